multicycle_ctrl: RTL

- Main control FSM for the multi-cycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback for the subset R-type, LW, SW and BEQ.
- It drives the 2-bit ALUop into the registered ALU-control decoder, the datapath mux selects, the write enables and a shared instruction/data memory request handshake.
- It sits between the IR opcode field and the datapath.

---
 rtl/multicycle_pkg.sv | 103 ++++++++++
 rtl/multicycle_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, opcode, ALUop and mux-select definitions for the multi-cycle control FSM
//
// Purpose: shared types and constants for multicycle_ctrl.
// Contents: state_t (4-bit state encoding), opcode/ALUop/mux-select
// constants, ctrl_t (bundle of per-state datapath controls) and
// state_ctrl(), which maps a state to its controls.

package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXEC_R    = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic I_OR_D_PC  = 1'b0;
  localparam logic I_OR_D_ALU = 1'b1;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       pc_write_cond;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // Moore controls asserted while sitting in state s; everything else is 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.i_or_d    = I_OR_D_PC;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
      end
      ST_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = SRC_A_REG;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_MEM_READ: begin
        c.mem_req = 1'b1;
        c.i_or_d  = I_OR_D_ALU;
      end
      ST_MEM_WRITE: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = I_OR_D_ALU;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = SRC_A_REG;
        c.alu_src_b = SRC_B_REG;
      end
      ST_ALU_WB: c.reg_write = 1'b1;
      ST_BRANCH: begin
        c.alu_src_a     = SRC_A_REG;
        c.alu_src_b     = SRC_B_REG;
        c.pc_write_cond = 1'b1;
        c.pc_src        = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I datapath (R, LW, SW, BEQ)
//
// Purpose: sequences fetch/decode/execute/memory/writeback and drives the
// datapath controls, the shared memory request and a retired-instruction counter.
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   run                      execute (1) or park in IDLE at the next boundary (0)
//   opcode                   IR[6:0], valid from DECODE onward
//   mem_ready                memory completes the current access this cycle
//   mem_req, mem_we, i_or_d  memory request, write qualifier, address select
//   ir_write, pc_write       IR/OldPC load and PC<=PC+4, in the completing FETCH cycle
//   pc_write_cond, pc_src    branch PC load and PC source
//   alu_src_a, alu_src_b     ALU operand selects
//   alu_op                   ALUop into the registered ALU-control decoder
//   reg_write, mem_to_reg    register writeback enable and source
//   illegal_op, retire       one-cycle event pulses
//   retire_count             wrapping retired-instruction count

module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   complete;
  logic   illegal;

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_IDLE:      if (run) next_state = ST_FETCH;
      ST_FETCH:     if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_R:         next_state = ST_EXEC_R;
          OP_BEQ:       next_state = ST_BRANCH;
          default: begin
            illegal    = 1'b1;
            next_state = run ? ST_FETCH : ST_IDLE;
          end
        endcase
      end
      // opcode[5] separates SW (0100011) from LW (0000011).
      ST_MEM_ADDR:  next_state = opcode[5] ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) next_state = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) complete = 1'b1;
      ST_EXEC_R:    next_state = ST_ALU_WB;
      ST_MEM_WB, ST_ALU_WB, ST_BRANCH: complete = 1'b1;
      default:      next_state = ST_IDLE;
    endcase
    if (complete) next_state = run ? ST_FETCH : ST_IDLE;
    if (res) next_state = ST_IDLE;
  end

  // Moore controls are registered from next_state so they line up with the
  // state they belong to; a reset forces next_state to IDLE and clears them.
  always_ff @(posedge clk) begin
    if (res) begin
      state        <= ST_IDLE;
      ctrl         <= '0;
      retire_count <= '0;
    end else begin
      state <= next_state;
      ctrl  <= state_ctrl(next_state);
      if (complete) retire_count <= retire_count + CNT_W'(1);
    end
  end

  assign mem_req       = ctrl.mem_req;
  assign mem_we        = ctrl.mem_we;
  assign i_or_d        = ctrl.i_or_d;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;

  // The ALU-control decoder adds a register stage, so ALUop is issued one
  // cycle early from next_state.
  always_comb begin
    alu_op = ALUOP_ADD;
    if (next_state == ST_EXEC_R) alu_op = ALUOP_FUNCT;
    if (next_state == ST_BRANCH) alu_op = ALUOP_SUB;
  end

  // Event outputs depend on this cycle's inputs; an aborting reset suppresses them.
  assign ir_write   = (state == ST_FETCH) && mem_ready && !res;
  assign pc_write   = ir_write;
  assign illegal_op = illegal && !res;
  assign retire     = complete && !res;

endmodule
